// File: rtl/lifo_stack_param_if.sv
// Control and data bundle between the decoded PUSH/POP/CALL/RET logic and the LIFO.
// CW is derived here so both sides agree on the count/high-water width.
interface lifo_stack_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             flush;
    logic             clear_err;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
    logic [CW-1:0]    high_water;

    modport master (
        output push, pop, flush, clear_err, value,
        input  out, top, count, empty, full, overflow, underflow, high_water
    );

    modport slave (
        input  push, pop, flush, clear_err, value,
        output out, top, count, empty, full, overflow, underflow, high_water
    );
endinterface

// File: rtl/lifo_stack_param.sv
// Parametrised push/pop stack with occupancy, sticky error flags, flush,
// replace-top on simultaneous push+pop, zero-latency pop data and a high-water mark.
module lifo_stack_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input logic             clk,
    input logic             rst,
    lifo_stack_param_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] LIMIT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    count_dec;
    logic [CW-1:0]    high_water;
    logic [CW-1:0]    high_water_next;
    logic             overflow;
    logic             underflow;
    logic             ovf_set;
    logic             unf_set;
    logic             is_empty;
    logic             is_full;
    logic             do_write;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    wr_addr;

    assign is_empty  = (count == '0);
    assign is_full   = (count == LIMIT);
    assign count_dec = count - ONE;
    assign top_idx   = count_dec[AW-1:0];
    assign wr_idx    = count[AW-1:0];

    always_comb begin
        count_next = count;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        do_write   = 1'b0;
        wr_addr    = wr_idx;
        if (bus.flush) begin
            count_next = '0;
        end else if (bus.push && !bus.pop) begin
            if (!is_full) begin
                do_write   = 1'b1;
                count_next = count + ONE;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (bus.pop && !bus.push) begin
            if (!is_empty) begin
                count_next = count_dec;
            end else begin
                unf_set = 1'b1;
            end
        end else if (bus.push && bus.pop) begin
            // Replace-top keeps occupancy, so a full stack never overflows here
            if (!is_empty) begin
                do_write = 1'b1;
                wr_addr  = top_idx;
            end else begin
                do_write   = 1'b1;
                count_next = ONE;
                unf_set    = 1'b1;
            end
        end
    end

    always_comb begin
        high_water_next = high_water;
        if (bus.clear_err) begin
            high_water_next = '0;
        end else if (count_next > high_water) begin
            high_water_next = count_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            high_water <= '0;
        end else begin
            count      <= count_next;
            overflow   <= ovf_set | (overflow & ~bus.clear_err);
            underflow  <= unf_set | (underflow & ~bus.clear_err);
            high_water <= high_water_next;
        end
    end

    // Storage is not reset; writes are suppressed while reset is held
    always_ff @(posedge clk) begin
        if (rst && do_write) begin
            mem[wr_addr] <= bus.value;
        end
    end

    assign bus.out        = (bus.pop && !bus.flush && !is_empty) ? mem[top_idx] : '0;
    assign bus.top        = is_empty ? '0 : mem[top_idx];
    assign bus.count      = count;
    assign bus.empty      = is_empty;
    assign bus.full       = is_full;
    assign bus.overflow   = overflow;
    assign bus.underflow  = underflow;
    assign bus.high_water = high_water;
endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed bench for lifo_stack_param: a queue-based reference stack predicts state,
// and predicted pop data goes through a scoreboard queue compared in the pop cycle.
module tb_lifo_stack_param;
    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst;

    lifo_stack_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    lifo_stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] model_stack [$];
    logic [WIDTH-1:0] exp_out_q [$];
    logic             m_ovf;
    logic             m_unf;
    int               m_hw;
    int               total_count;
    int               pass_count;
    int               fail_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_hw  = 0;
    endtask

    task automatic checkState(input string tag);
        logic [WIDTH-1:0] exp_top;
        int sz;
        sz = model_stack.size();
        exp_top = (sz > 0) ? model_stack[sz-1] : '0;
        check({tag, ".count"},      64'(bus.count),      64'(sz));
        check({tag, ".empty"},      64'(bus.empty),      64'(sz == 0));
        check({tag, ".full"},       64'(bus.full),       64'(sz == DEPTH));
        check({tag, ".top"},        64'(bus.top),        64'(exp_top));
        check({tag, ".overflow"},   64'(bus.overflow),   64'(m_ovf));
        check({tag, ".underflow"},  64'(bus.underflow),  64'(m_unf));
        check({tag, ".high_water"}, 64'(bus.high_water), 64'(m_hw));
    endtask

    task automatic checkOutput(input string tag);
        logic [WIDTH-1:0] exp;
        if (exp_out_q.size() == 0) begin
            check({tag, ".scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            exp = exp_out_q.pop_front();
            check({tag, ".out"}, 64'(bus.out), 64'(exp));
        end
    endtask

    // Drive one cycle of control, check pop data mid-cycle, then check registered state
    task automatic applyStimulus(input logic p, input logic o, input logic f, input logic c,
                                 input logic [WIDTH-1:0] v, input string tag);
        int sz;
        logic ovf_s;
        logic unf_s;
        @(negedge clk);
        bus.push      = p;
        bus.pop       = o;
        bus.flush     = f;
        bus.clear_err = c;
        bus.value     = v;
        sz = model_stack.size();
        exp_out_q.push_back((o && !f && sz > 0) ? model_stack[sz-1] : '0);
        #2;
        checkOutput(tag);
        @(posedge clk);
        #1;
        ovf_s = 1'b0;
        unf_s = 1'b0;
        if (f) begin
            model_stack.delete();
        end else if (p && !o) begin
            if (sz < DEPTH) model_stack.push_back(v);
            else ovf_s = 1'b1;
        end else if (o && !p) begin
            if (sz > 0) void'(model_stack.pop_back());
            else unf_s = 1'b1;
        end else if (p && o) begin
            if (sz > 0) model_stack[sz-1] = v;
            else begin
                model_stack.push_back(v);
                unf_s = 1'b1;
            end
        end
        m_ovf = (c ? 1'b0 : m_ovf) | ovf_s;
        m_unf = (c ? 1'b0 : m_unf) | unf_s;
        m_hw  = c ? 0 : ((model_stack.size() > m_hw) ? model_stack.size() : m_hw);
        checkState(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, tag);
    endtask

    initial begin
        total_count = 0;
        pass_count  = 0;
        fail_count  = 0;
        model_reset();
        rst           = 1'b0;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.flush     = 1'b0;
        bus.clear_err = 1'b0;
        bus.value     = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        checkState("reset_held");
        check("reset_held.out", 64'(bus.out), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        idle("reset_idle");

        // LIFO ordering
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h11, "lifo_push0");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h22, "lifo_push1");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h33, "lifo_push2");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, $sformatf("lifo_pop%0d", i));

        // Fill to full, overflow, replace-top while full
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(i), $sformatf("fill%0d", i));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, "overflow_push");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hBB, "full_replace");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'hCC, "ovf_vs_clear");
        idle("hw_after_clear_full");

        // Empty behaviour and underflow
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0, "flush_and_clear");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, "underflow_pop");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h5C, "empty_push_pop");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, "clear_err");
        idle("hw_restart");

        // Flush beats push and pop
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, "flush_pre");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(8'h40 + i), $sformatf("pre_flush_push%0d", i));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE, "flush_priority");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h77, "after_flush_push");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, "after_flush_pop");

        // Asynchronous reset between edges
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(8'h60 + i), $sformatf("pre_reset_push%0d", i));
        bus.push = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checkState("async_reset");
        @(negedge clk);
        bus.push  = 1'b1;
        bus.value = 8'h99;
        @(posedge clk);
        #1;
        checkState("push_in_reset");
        @(negedge clk);
        bus.push = 1'b0;
        rst      = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, "post_reset_push");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, "post_reset_pop");
        idle("final_idle");

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule

// File: doc/lifo_stack_param.md
Name: lifo_stack_param

Overview:
- Parametrised hardware LIFO (push/pop stack) for LEG-class CPU call/return and scratch-stack use.
- Generalises the fixed 8-bit x 32-entry stack to configurable width and depth.
- Adds occupancy, full/empty flags, sticky overflow/underflow error flags, flush, legal simultaneous push+pop (replace-top), peek and a high-water mark.
- Sits beside the register file; driven by decoded PUSH/POP/CALL/RET control.

Parameters:
- WIDTH, 8, data word width in bits (1..64).
- DEPTH, 32, number of entries (2..256).
- CW, $clog2(DEPTH+1), width of count/high-water outputs (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- push  in  1  write value onto stack this cycle.
- pop  in  1  remove top entry this cycle.
- flush  in  1  synchronous empty of the stack.
- clear_err  in  1  synchronous clear of overflow, underflow and high_water.
- value  in  WIDTH  data to push.
- out  out  WIDTH  popped data, valid in the pop cycle; 0 otherwise.
- top  out  WIDTH  peek of current top entry without popping; 0 when empty.
- count  out  CW  number of valid entries (0..DEPTH).
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: push refused because full.
- underflow  out  1  sticky: pop attempted while empty.
- high_water  out  CW  maximum count reached since reset/clear_err.

Behaviour:
- Reset: rst low forces, asynchronously, count=0, overflow=0, underflow=0, high_water=0. Hence empty=1, full=0, top=0, out=0. Storage array is not reset and is unobservable while empty.
- Reset mid-operation: any push/pop in the same cycle is discarded; normal operation resumes on the first rising edge after rst returns high.
- Storage: DEPTH x WIDTH register array, addressed by sp=count. The top entry is mem[count-1].
- out is combinational:
  - pop=1, flush=0 and count>0: out=mem[count-1].
  - Otherwise: out=0.
  - Zero read latency; the consumer samples out in the same cycle it asserts pop.
- top is combinational: mem[count-1] when count>0, else 0.
- Per-edge priority, highest first:
  1. flush=1: count<=0; push and pop ignored; no error set.
  2. push=1, pop=0:
     - count<DEPTH: mem[count]<=value, count<=count+1.
     - Full: write dropped, count unchanged, overflow<=1.
  3. pop=1, push=0:
     - count>0: count<=count-1.
     - Empty: count unchanged, underflow<=1, out=0.
  4. push=1, pop=1:
     - count>0, including full: out=old top, mem[count-1]<=value, count unchanged. No overflow, even when full.
     - count==0: push is performed (mem[0]<=value, count<=1), pop is flagged underflow<=1, out=0.
  5. Neither: no change.
- clear_err=1: overflow, underflow <=0 and high_water<=0 (count-based high-water restarts next edge). Error set in the same cycle as clear_err wins (flag ends 1).
- high_water <= max(high_water, next count) each edge.
- Flags empty, full and count reflect registered state; they change one edge after the causing push/pop.
- No wrap-around: count saturates at 0 and DEPTH. The pointer never wraps into stale entries.
- X on push/pop is not supported; the bench drives only 0/1.

Test Plan:
- Reset/idle: hold rst=0 3 cycles, release -> count=0, empty=1, full=0, top=0, out=0, flags 0, high_water=0.
- LIFO order (WIDTH=8, DEPTH=32): push 0x11, 0x22, 0x33 on consecutive edges -> count=3, top=0x33. Then pop 3 cycles -> out=0x33, 0x22, 0x11 in the pop cycles, then empty=1, high_water=3.
- Full/overflow: push 32 values 0..31 -> full=1, count=32. Push 0xAA -> overflow=1, count=32, top=31. Push+pop with 0xBB -> out=31, top=0xBB, count=32, underflow=0.
- Empty/underflow: from empty, pop -> out=0, underflow=1, count=0. Push+pop with 0x5C on empty -> count=1, top=0x5C, out=0. clear_err -> both flags 0, high_water=1 after next edge.
- Flush priority: with 5 entries, assert flush+push+pop together -> out=0, count=0, no flags set. A push afterwards lands at entry 0.
- Async reset mid-stream: with count=7, drop rst between edges -> count=0 and high_water=0 immediately, before the next clk edge. Release -> push 0x01, then pop -> out=0x01.
